// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP execute-stage definitions.
//   fpusel_e    decoded FP op select codes (5'b11111 = no FP op)
//   fpu_class_e dispatch class of an op: NONE, SIMPLE, PIPE, ITER
//   fpu_class() maps an fpusel code to its dispatch class
//   fpu_to_int() flags ops whose destination is the integer register file
package fpu_pkg;

  localparam int unsigned FFLAGS_W  = 5;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [4:0] {
    FP_FADD     = 5'b00000,
    FP_FSUB     = 5'b00001,
    FP_FMUL     = 5'b00010,
    FP_FDIV     = 5'b00011,
    FP_FSQRT    = 5'b00100,
    FP_FSGNJ    = 5'b00101,
    FP_FSGNJN   = 5'b00110,
    FP_FSGNJX   = 5'b00111,
    FP_FMIN     = 5'b01000,
    FP_FMAX     = 5'b01001,
    FP_FEQ      = 5'b01010,
    FP_FLT      = 5'b01011,
    FP_FLE      = 5'b01100,
    FP_FCLASS   = 5'b01101,
    FP_FMV_X_W  = 5'b01110,
    FP_FMV_W_X  = 5'b01111,
    FP_FMADD    = 5'b10000,
    FP_FMSUB    = 5'b10001,
    FP_FNMSUB   = 5'b10010,
    FP_FNMADD   = 5'b10011,
    FP_FCVT_W_S = 5'b10100,
    FP_FCVT_WU_S= 5'b10101,
    FP_FCVT_S_W = 5'b10110,
    FP_FCVT_S_WU= 5'b10111,
    FP_NONE     = 5'b11111
  } fpusel_e;

  typedef enum logic [1:0] {
    NONE,
    SIMPLE,
    PIPE,
    ITER
  } fpu_class_e;

  function automatic fpu_class_e fpu_class(input logic [4:0] sel);
    fpu_class_e c;
    if (sel == FP_NONE)
      c = NONE;
    else if (sel == FP_FDIV || sel == FP_FSQRT)
      c = ITER;
    else if (sel >= FP_FSGNJ && sel <= FP_FMV_W_X)
      c = SIMPLE;
    else
      c = PIPE;
    return c;
  endfunction

  function automatic logic fpu_to_int(input logic [4:0] sel);
    logic r;
    case (sel)
      FP_FEQ, FP_FLT, FP_FLE, FP_FCLASS, FP_FMV_X_W,
      FP_FCVT_W_S, FP_FCVT_WU_S: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// fpu_lat_counter: loadable 4-bit down-counter with zero flag.
//   clk, rst_n  clock, async active-low reset
//   load        load load_val this cycle (has priority over dec)
//   load_val    value to load
//   dec         decrement by one; saturates at zero
//   cnt         current count
//   zero        cnt == 0
module fpu_lat_counter
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq: FP execute-stage issue sequencer.
// Registers one decoded FP op, dispatches it to the fixed-latency FU or the
// iterative div/sqrt unit, collects the result and presents a one-cycle
// writeback beat. ex_busy stalls decode while an op is in flight.
//   id_*          decoded op from decode (id_fpusel 5'b11111 = no op)
//   flush         kill in-flight op / suppress pending writeback
//   ex_busy       stall request to decode
//   fu_*          pipelined FU interface (fu_a/b/c shared with the iter unit)
//   iter_*        iterative div/sqrt unit interface
//   wb_*          writeback beat (wb_to_int: integer-file destination)
//   wdt_err       iterative-unit timeout pulse
// Optional feature macro: FPU_ITER_WDT_EN enables the WDT_CYC iterative-unit
// watchdog; without it ITER waits indefinitely and wdt_err is tied 0.
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned SIMPLE_LAT = 1,
  parameter int unsigned WDT_CYC    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [4:0]          id_fpusel,
  input  logic [4:0]          id_rd,
  input  logic [2:0]          id_rm,
  input  logic [31:0]         id_a,
  input  logic [31:0]         id_b,
  input  logic [31:0]         id_c,
  input  logic                flush,
  output logic                ex_busy,
  output logic                fu_start,
  output logic [4:0]          fu_op,
  output logic [2:0]          fu_rm,
  output logic [31:0]         fu_a,
  output logic [31:0]         fu_b,
  output logic [31:0]         fu_c,
  input  logic [31:0]         fu_result,
  input  logic [FFLAGS_W-1:0] fu_flags,
  output logic                iter_start,
  output logic                iter_sqrt,
  output logic                iter_kill,
  input  logic                iter_done,
  input  logic [31:0]         iter_result,
  input  logic [FFLAGS_W-1:0] iter_flags,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic [FFLAGS_W-1:0] wb_flags,
  output logic                wb_to_int,
  output logic                wdt_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIPE,
    ST_ITER,
    ST_WB
  } state_e;

  localparam logic [3:0] PIPE_LAT_C   = 4'(PIPE_LAT);
  localparam logic [3:0] SIMPLE_LAT_C = 4'(SIMPLE_LAT);

  state_e     state;
  fpu_class_e id_class;
  logic       accept;
  logic [3:0] lat_load;
  logic [3:0] lat_cnt;
  logic       lat_zero;
  logic [4:0] op_rd;
  logic       wb_q;
  logic       wdt_expire;

  assign id_class = fpu_class(id_fpusel);
  assign accept   = (state == ST_IDLE || state == ST_WB) && id_valid && !flush
                    && (id_class != NONE);
  assign ex_busy  = (state == ST_PIPE) || (state == ST_ITER) || accept;
  assign lat_load = (id_class == SIMPLE) ? SIMPLE_LAT_C : PIPE_LAT_C;

  // The writeback beat is registered; only a same-cycle flush gates it off.
  assign wb_valid = wb_q && !flush;

  fpu_lat_counter u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (lat_load),
    .dec      (state == ST_PIPE),
    .cnt      (lat_cnt),
    .zero     (lat_zero)
  );

`ifdef FPU_ITER_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);
  logic [WDT_W-1:0] wdt_cnt;

  // Counts cycles spent in ITER; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wdt_cnt <= '0;
    else if (state != ST_ITER)
      wdt_cnt <= '0;
    else
      wdt_cnt <= wdt_cnt + WDT_W'(1);
  end

  assign wdt_expire = (state == ST_ITER) && (wdt_cnt == WDT_W'(WDT_CYC - 1));
`else
  assign wdt_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      fu_start   <= 1'b0;
      fu_op      <= '0;
      fu_rm      <= '0;
      fu_a       <= '0;
      fu_b       <= '0;
      fu_c       <= '0;
      op_rd      <= '0;
      iter_start <= 1'b0;
      iter_sqrt  <= 1'b0;
      iter_kill  <= 1'b0;
      wb_q       <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_flags   <= '0;
      wb_to_int  <= 1'b0;
      wdt_err    <= 1'b0;
    end else begin
      fu_start   <= 1'b0;
      iter_start <= 1'b0;
      iter_kill  <= 1'b0;
      wdt_err    <= 1'b0;
      wb_q       <= 1'b0;

      if (accept) begin
        fu_op     <= id_fpusel;
        fu_rm     <= id_rm;
        fu_a      <= id_a;
        fu_b      <= id_b;
        fu_c      <= id_c;
        op_rd     <= id_rd;
        iter_sqrt <= (id_fpusel == FP_FSQRT);
        if (id_class == ITER) begin
          iter_start <= 1'b1;
          state      <= ST_ITER;
        end else begin
          fu_start <= 1'b1;
          state    <= ST_PIPE;
        end
      end else begin
        case (state)
          ST_PIPE: begin
            if (flush) begin
              state <= ST_IDLE;
            end else if (lat_zero) begin
              wb_q      <= 1'b1;
              wb_rd     <= op_rd;
              wb_data   <= fu_result;
              wb_flags  <= fu_flags;
              wb_to_int <= fpu_to_int(fu_op);
              state     <= ST_WB;
            end
          end
          ST_ITER: begin
            if (flush) begin
              iter_kill <= 1'b1;
              state     <= ST_IDLE;
            end else if (iter_done) begin
              wb_q      <= 1'b1;
              wb_rd     <= op_rd;
              wb_data   <= iter_result;
              wb_flags  <= iter_flags;
              wb_to_int <= fpu_to_int(fu_op);
              state     <= ST_WB;
            end else if (wdt_expire) begin
              wdt_err   <= 1'b1;
              iter_kill <= 1'b1;
              wb_q      <= 1'b1;
              wb_rd     <= op_rd;
              wb_data   <= CANON_NAN;
              wb_flags  <= 5'b10000;
              wb_to_int <= 1'b0;
              state     <= ST_WB;
            end
          end
          ST_WB:   state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_seq.sv
// tb_fpu_issue_seq: self-checking bench for fpu_issue_seq.
// Table of ops run through stub FU models, plus hand-written multi-cycle
// sequences; expected writebacks are queued when driven and compared by a
// monitor when wb_valid appears (or should have appeared).
module tb_fpu_issue_seq;
  import fpu_pkg::*;

  logic        clk, rst_n;
  logic        id_valid;
  logic [4:0]  id_fpusel, id_rd;
  logic [2:0]  id_rm;
  logic [31:0] id_a, id_b, id_c;
  logic        flush;
  logic        ex_busy, fu_start;
  logic [4:0]  fu_op;
  logic [2:0]  fu_rm;
  logic [31:0] fu_a, fu_b, fu_c, fu_result;
  logic [4:0]  fu_flags;
  logic        iter_start, iter_sqrt, iter_kill, iter_done;
  logic [31:0] iter_result;
  logic [4:0]  iter_flags;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  wb_flags;
  logic        wb_to_int, wdt_err;

  fpu_issue_seq #(.PIPE_LAT(3), .SIMPLE_LAT(1), .WDT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_fpusel(id_fpusel),
    .id_rd(id_rd), .id_rm(id_rm), .id_a(id_a), .id_b(id_b), .id_c(id_c),
    .flush(flush), .ex_busy(ex_busy), .fu_start(fu_start), .fu_op(fu_op),
    .fu_rm(fu_rm), .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c),
    .fu_result(fu_result), .fu_flags(fu_flags), .iter_start(iter_start),
    .iter_sqrt(iter_sqrt), .iter_kill(iter_kill), .iter_done(iter_done),
    .iter_result(iter_result), .iter_flags(iter_flags), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
    .wb_to_int(wb_to_int), .wdt_err(wdt_err)
  );

  typedef struct {
    logic [4:0]  sel;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  fl;
    int unsigned lat;
    logic        to_int;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] val;
    logic [4:0]  fl;
  } stub_t;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  fl;
    logic        to_int;
  } exp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned last_fu_start = 0, last_iter_start = 0, last_kill = 0, last_wdt = 0;
  int unsigned n_kill = 0, n_wdt = 0;

  stub_t fu_q[$];
  stub_t it_q[$];
  exp_t  sb[$];
  vec_t  vec[15];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stub FU and div/sqrt unit: drive the queued value exactly on its cycle,
  // junk otherwise.
  initial begin
    fu_result = '0; fu_flags = '0; iter_done = 1'b0; iter_result = '0; iter_flags = '0;
    forever begin
      @(posedge clk); #1;
      while (fu_q.size() > 0 && fu_q[0].cyc < cyc) void'(fu_q.pop_front());
      if (fu_q.size() > 0 && fu_q[0].cyc == cyc) begin
        fu_result = fu_q[0].val; fu_flags = fu_q[0].fl; void'(fu_q.pop_front());
      end else begin
        fu_result = 32'hDEAD_BEEF; fu_flags = 5'b11111;
      end
      while (it_q.size() > 0 && it_q[0].cyc < cyc) void'(it_q.pop_front());
      if (it_q.size() > 0 && it_q[0].cyc == cyc) begin
        iter_done = 1'b1; iter_result = it_q[0].val; iter_flags = it_q[0].fl;
        void'(it_q.pop_front());
      end else begin
        iter_done = 1'b0; iter_result = 32'hBAD0_0000; iter_flags = 5'b11111;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_v;
      exp_t e;
      if (fu_start)   last_fu_start = cyc;
      if (iter_start) last_iter_start = cyc;
      if (iter_kill) begin n_kill++; last_kill = cyc; end
      if (wdt_err)   begin n_wdt++;  last_wdt  = cyc; end
      while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
      exp_v = (sb.size() > 0 && sb[0].cyc == cyc);
      if (wb_valid || exp_v) begin
        chk("wb_valid", 64'(wb_valid), 64'(exp_v));
        if (wb_valid && exp_v) begin
          e = sb.pop_front();
          chk("wb_rd",     64'(wb_rd),     64'(e.rd));
          chk("wb_data",   64'(wb_data),   64'(e.data));
          chk("wb_flags",  64'(wb_flags),  64'(e.fl));
          chk("wb_to_int", 64'(wb_to_int), 64'(e.to_int));
        end else if (exp_v) begin
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [4:0] sel, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1; id_fpusel = sel; id_rd = rd; id_rm = rd[2:0];
    id_a = a; id_b = b; id_c = a ^ b;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_fpusel = 5'b11111;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({ex_busy, fu_start, iter_start, iter_sqrt, iter_kill, wb_valid,
                             wb_to_int, wdt_err, fu_op, fu_rm, wb_rd, wb_flags}), 64'd0);
    chk({tag, "_ab"}, {fu_a, fu_b}, 64'd0);
    chk({tag, "_cd"}, {fu_c, wb_data}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned t;
    step(); drive(v.sel, v.rd, v.a, v.b); t = cyc;
    fu_q.push_back(stub_t'{t + 1 + v.lat, v.res, v.fl});
    sb.push_back(exp_t'{t + v.lat + 2, v.rd, v.res, v.fl, v.to_int});
    #1 chk("busy_accept", 64'(ex_busy), 64'd1);
    step(); idle();
    chk("fu_op", 64'(fu_op), 64'(v.sel));
    chk("fu_rm", 64'(fu_rm), 64'(v.rd[2:0]));
    chk("fu_ab", {fu_a, fu_b}, {v.a, v.b});
    chk("fu_c",  64'(fu_c), 64'(v.a ^ v.b));
    repeat (v.lat + 1) step();
    #1 chk("busy_wb", 64'(ex_busy), 64'd0);
    chk("fu_start_cyc", 64'(last_fu_start), 64'(t + 1));
  endtask

  initial begin
    int unsigned t, k0;
    vec[0]  = '{FP_FADD,      5'd1,  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 3, 1'b0};
    vec[1]  = '{FP_FEQ,       5'd2,  32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, 5'b00000, 1, 1'b1};
    vec[2]  = '{FP_FMUL,      5'd3,  32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00001, 3, 1'b0};
    vec[3]  = '{FP_FMIN,      5'd4,  32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 5'b00000, 1, 1'b0};
    vec[4]  = '{FP_FCVT_W_S,  5'd5,  32'h40E0_0000, 32'h0,         32'h0000_0007, 5'b00001, 3, 1'b1};
    vec[5]  = '{FP_FCLASS,    5'd6,  32'h3F80_0000, 32'h0,         32'h0000_0040, 5'b00000, 1, 1'b1};
    vec[6]  = '{FP_FMADD,     5'd7,  32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5'b00100, 3, 1'b0};
    vec[7]  = '{FP_FMV_X_W,   5'd8,  32'h1234_5678, 32'h0,         32'h1234_5678, 5'b00000, 1, 1'b1};
    vec[8]  = '{FP_FCVT_S_W,  5'd9,  32'h0000_0003, 32'h0,         32'h4040_0000, 5'b00000, 3, 1'b0};
    vec[9]  = '{FP_FLT,       5'd10, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0001, 5'b00000, 1, 1'b1};
    vec[10] = '{FP_FLE,       5'd11, 32'h7FC0_0000, 32'h4000_0000, 32'h0000_0000, 5'b10000, 1, 1'b1};
    vec[11] = '{FP_FCVT_WU_S, 5'd12, 32'hBF80_0000, 32'h0,         32'h0000_0000, 5'b10000, 3, 1'b1};
    vec[12] = '{FP_FSGNJ,     5'd13, 32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 5'b00000, 1, 1'b0};
    vec[13] = '{FP_FMV_W_X,   5'd14, 32'hCAFE_F00D, 32'h0,         32'hCAFE_F00D, 5'b00000, 1, 1'b0};
    vec[14] = '{5'b11001,     5'd15, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'b01000, 3, 1'b0};

    rst_n = 1'b0; flush = 1'b0; idle(); id_rd = '0; id_rm = '0; id_a = '0; id_b = '0; id_c = '0;
    repeat (3) step();
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    step();
    check_all_zero("rst_rel");

    // iter_done while idle must be ignored
    it_q.push_back(stub_t'{cyc + 1, 32'h1234_0000, 5'b00000});
    repeat (3) step();
    chk("busy_idle_done", 64'(ex_busy), 64'd0);

    foreach (vec[i]) run_vec(vec[i]);

    // fdiv, iter_done 10 cycles after iter_start
    step(); drive(FP_FDIV, 5'd16, 32'h3F80_0000, 32'h4000_0000); t = cyc;
    it_q.push_back(stub_t'{t + 11, 32'h3F00_0000, 5'b00000});
    sb.push_back(exp_t'{t + 12, 5'd16, 32'h3F00_0000, 5'b00000, 1'b0});
    step(); idle();
    chk("iter_sqrt_div", 64'(iter_sqrt), 64'd0);
    for (int k = 0; k < 11; k++) begin
      #1 chk("busy_div", 64'(ex_busy), 64'd1);
      step();
    end
    #1 chk("busy_div_wb", 64'(ex_busy), 64'd0);
    chk("iter_start_cyc", 64'(last_iter_start), 64'(t + 1));

    // fsqrt killed by flush 4 cycles after iter_start; late iter_done ignored
    step(); drive(FP_FSQRT, 5'd17, 32'h4080_0000, 32'h0); t = cyc; k0 = n_kill;
    it_q.push_back(stub_t'{t + 8, 32'h4000_0000, 5'b00000});
    step(); idle();
    chk("iter_sqrt_sqrt", 64'(iter_sqrt), 64'd1);
    while (cyc < t + 5) step();
    flush = 1'b1;
    step(); flush = 1'b0;
    #1 chk("busy_after_kill", 64'(ex_busy), 64'd0);
    while (cyc < t + 12) step();
    chk("kill_count", 64'(n_kill - k0), 64'd1);
    chk("kill_cyc", 64'(last_kill), 64'(t + 6));
    run_vec(vec[0]);

    // back-to-back fmul, second accepted in WB
    step(); drive(FP_FMUL, 5'd18, 32'h4000_0000, 32'h4000_0000); t = cyc;
    fu_q.push_back(stub_t'{t + 4, 32'h4080_0000, 5'b00000});
    sb.push_back(exp_t'{t + 5, 5'd18, 32'h4080_0000, 5'b00000, 1'b0});
    step(); idle();
    while (cyc < t + 5) step();
    drive(FP_FMUL, 5'd19, 32'h4040_0000, 32'h4040_0000);
    fu_q.push_back(stub_t'{t + 9, 32'h4110_0000, 5'b00001});
    sb.push_back(exp_t'{t + 10, 5'd19, 32'h4110_0000, 5'b00001, 1'b0});
    #1 chk("busy_b2b", 64'(ex_busy), 64'd1);
    step(); idle();
    chk("b2b_fu_start", 64'(fu_start), 64'd1);
    while (cyc < t + 11) step();

    // flush with id_valid: not accepted
    step(); drive(FP_FADD, 5'd20, 32'h0, 32'h0); flush = 1'b1;
    #1 chk("busy_flush_id", 64'(ex_busy), 64'd0);
    step(); idle(); flush = 1'b0;
    chk("no_start_flush_id", 64'({fu_start, iter_start}), 64'd0);
    repeat (6) step();

    // flush during WB suppresses the beat
    step(); drive(FP_FADD, 5'd21, 32'h0, 32'h0); t = cyc;
    fu_q.push_back(stub_t'{t + 4, 32'h5555_5555, 5'b00000});
    step(); idle();
    while (cyc < t + 5) step();
    flush = 1'b1;
    #1 chk("wb_flushed", 64'(wb_valid), 64'd0);
    step(); flush = 1'b0;
    #1 chk("busy_after_wbflush", 64'(ex_busy), 64'd0);

    // flush in PIPE: no writeback, no iter_kill
    step(); drive(FP_FMUL, 5'd22, 32'h0, 32'h0); t = cyc; k0 = n_kill;
    fu_q.push_back(stub_t'{t + 4, 32'h6666_6666, 5'b00000});
    step(); idle();
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    #1 chk("busy_pipe_flush", 64'(ex_busy), 64'd0);
    while (cyc < t + 8) step();
    chk("pipe_flush_nokill", 64'(n_kill - k0), 64'd0);

    // async reset mid-PIPE
    step(); drive(FP_FADD, 5'd23, 32'h3F80_0000, 32'h3F80_0000); t = cyc; k0 = n_kill;
    fu_q.push_back(stub_t'{t + 4, 32'h4000_0000, 5'b00000});
    step(); idle();
    step(); rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    step(); step(); rst_n = 1'b1;
    repeat (8) step();
    chk("rst_mid_nokill", 64'(n_kill - k0), 64'd0);
    chk("rst_mid_busy", 64'(ex_busy), 64'd0);

`ifdef FPU_ITER_WDT_EN
    // watchdog expiry with no iter_done
    step(); drive(FP_FDIV, 5'd24, 32'h3F80_0000, 32'h0); t = cyc; k0 = n_kill;
    sb.push_back(exp_t'{t + 9, 5'd24, CANON_NAN, 5'b10000, 1'b0});
    step(); idle();
    while (cyc < t + 12) step();
    chk("wdt_cyc", 64'(last_wdt), 64'(t + 9));
    chk("wdt_kill_cyc", 64'(last_kill), 64'(t + 9));
    chk("wdt_kill_count", 64'(n_kill - k0), 64'd1);
`else
    chk("wdt_tied", 64'(n_wdt), 64'd0);
`endif

    repeat (3) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
